sme_match_serializer: RTL and testbench

//  Downstream of the port_group stage. Consumes the 8-lane x 16-bit rule-ID beat (0 = no match in lane)
//  and emits non-zero rule IDs one per cycle on a valid/ready stream.

---
 rtl/sme_pkg.sv | 32 +++
 rtl/sme_lane_prio_enc.sv | 20 ++
 rtl/sme_match_serializer.sv | 186 ++++++++++++++++++
 tb/tb_sme_match_serializer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sme_pkg.sv
// Shared constants, types and helpers for the match serializer block
// (sme_match_serializer and its lane priority encoder).
package sme_pkg;

    localparam int LANES  = 8;
    localparam int RULE_W = 16;
    localparam int CNT_W  = 16;
    localparam int IDX_W  = $clog2(LANES);

    typedef logic [RULE_W-1:0] rule_id_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [LANES-1:0]  lane_mask_t;
    typedef logic [IDX_W-1:0]  lane_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        MARK  = 2'd2
    } ser_state_t;

    // Match counter increment that sticks at all-ones instead of wrapping.
    function automatic cnt_t cnt_sat_inc(input cnt_t c);
        cnt_t r;
        if (c == {CNT_W{1'b1}}) begin
            r = c;
        end else begin
            r = c + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/sme_lane_prio_enc.sv
// Lowest-index-first priority encoder over the pending-lane mask.
// o_any flags that at least one lane is still pending.
module sme_lane_prio_enc
    import sme_pkg::*;
(
    input  logic [LANES-1:0] i_mask,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Scan from the top lane down so the lowest set lane is the last one written.
    always_comb begin
        o_idx = {IDX_W{1'b0}};
        for (int i = LANES - 1; i >= 0; i--) begin
            o_idx = i_mask[i] ? lane_idx_t'(i) : o_idx;
        end
        o_any = |i_mask;
    end

endmodule

// File: rtl/sme_match_serializer.sv
// Serializes 8-lane rule-ID beats into one non-zero ID per cycle and closes every packet
// with a marker word carrying its match count. Build macro SME_SER_DEDUP_EN drops repeats.
module sme_match_serializer
    import sme_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*RULE_W-1:0] s_rule_data,
    input  logic                    s_rule_valid,
    input  logic                    s_rule_eop,
    output logic                    s_rule_ready,
    output logic [RULE_W-1:0]       m_rule_id,
    output logic                    m_rule_valid,
    output logic                    m_rule_last,
    output logic [CNT_W-1:0]        m_rule_cnt,
    input  logic                    m_rule_ready
);

    ser_state_t r_state;
    ser_state_t w_state_nxt;
    rule_id_t   r_lanes [LANES];
    lane_mask_t r_mask;
    logic       r_eop_pend;
    cnt_t       r_cnt;
    logic       r_in_ready;

    rule_id_t   w_beat_lanes [LANES];
    lane_mask_t w_beat_mask;
    lane_mask_t w_mask_clr;
    lane_idx_t  w_idx;
    logic       w_any;
    logic       w_dup;
    logic       w_accept;
    logic       w_step;
    logic       w_emit;
    logic       w_mark_done;
    rule_id_t   w_sel_id;
    logic       w_out_valid;
    rule_id_t   w_out_id;
    logic       w_out_last;
    cnt_t       w_out_cnt;

    // Split the flat input beat into lanes and flag the non-zero ones.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_beat_lanes[i] = s_rule_data[i*RULE_W +: RULE_W];
            w_beat_mask[i]  = |s_rule_data[i*RULE_W +: RULE_W];
        end
    end

    sme_lane_prio_enc u_prio_enc (
        .i_mask (r_mask),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    assign w_sel_id = r_lanes[w_idx];

`ifdef SME_SER_DEDUP_EN
    rule_id_t r_last_id;
    logic     r_last_vld;

    assign w_dup = r_last_vld & (w_sel_id == r_last_id);

    // Remember the last ID emitted in the current packet; the marker closes the packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_id  <= {RULE_W{1'b0}};
            r_last_vld <= 1'b0;
        end else if (w_emit) begin
            r_last_id  <= w_sel_id;
            r_last_vld <= 1'b1;
        end else if (w_mark_done) begin
            r_last_vld <= 1'b0;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, datapath strobes and the output word, all from registered state.
    always_comb begin
        w_state_nxt       = r_state;
        w_accept          = 1'b0;
        w_step            = 1'b0;
        w_emit            = 1'b0;
        w_mark_done       = 1'b0;
        w_mask_clr        = r_mask;
        w_mask_clr[w_idx] = 1'b0;
        w_out_valid       = 1'b0;
        w_out_id          = {RULE_W{1'b0}};
        w_out_last        = 1'b0;
        w_out_cnt         = {CNT_W{1'b0}};
        case (r_state)
            IDLE: begin
                w_accept = s_rule_valid & r_in_ready;
                if (w_accept && (|w_beat_mask)) begin
                    w_state_nxt = DRAIN;
                end else if (w_accept && s_rule_eop) begin
                    w_state_nxt = MARK;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            DRAIN: begin
                // A duplicate lane is retired silently in its own cycle.
                w_out_valid = w_any & ~w_dup;
                w_out_id    = w_out_valid ? w_sel_id : {RULE_W{1'b0}};
                if (!w_any) begin
                    w_state_nxt = IDLE;
                end else if (w_dup || m_rule_ready) begin
                    w_step = 1'b1;
                    w_emit = ~w_dup;
                    if (|w_mask_clr) begin
                        w_state_nxt = DRAIN;
                    end else if (r_eop_pend) begin
                        w_state_nxt = MARK;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            MARK: begin
                w_out_valid = 1'b1;
                w_out_last  = 1'b1;
                w_out_cnt   = r_cnt;
                if (m_rule_ready) begin
                    w_mark_done = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = MARK;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Lane buffer, pending mask, end-of-packet flag, match counter and input ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                r_lanes[i] <= {RULE_W{1'b0}};
            end
            r_mask     <= {LANES{1'b0}};
            r_eop_pend <= 1'b0;
            r_cnt      <= {CNT_W{1'b0}};
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= (w_state_nxt == IDLE);
            if (w_accept) begin
                for (int i = 0; i < LANES; i++) begin
                    r_lanes[i] <= w_beat_lanes[i];
                end
                r_mask     <= w_beat_mask;
                r_eop_pend <= s_rule_eop;
            end else if (w_step) begin
                r_mask <= w_mask_clr;
            end
            if (w_emit) begin
                r_cnt <= cnt_sat_inc(r_cnt);
            end else if (w_mark_done) begin
                r_cnt <= {CNT_W{1'b0}};
            end
        end
    end

    assign s_rule_ready = r_in_ready;
    assign m_rule_valid = w_out_valid;
    assign m_rule_id    = w_out_id;
    assign m_rule_last  = w_out_last;
    assign m_rule_cnt   = w_out_cnt;

endmodule

// File: tb/tb_sme_match_serializer.sv
// Self-checking bench for sme_match_serializer: table vectors, hand-written corner sequences
// and randomized packets against a queue-based reference model. Honors SME_SER_DEDUP_EN.
module tb_sme_match_serializer;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] s_data;
    logic         s_valid;
    logic         s_eop;
    logic         s_ready;
    logic [15:0]  m_id;
    logic         m_valid;
    logic         m_last;
    logic [15:0]  m_cnt;
    logic         m_ready;

    int checks   = 0;
    int failures = 0;
    int rdy_mode = 1;

    // Word layout: {id[15:0], last, cnt[15:0]}; cnt is 0 for data words.
    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];
    int          mdl_cnt     = 0;
    logic [15:0] mdl_last    = 16'h0000;
    logic        mdl_last_ok = 1'b0;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   n;
        logic [127:0] ids;
        logic [15:0]  cnt;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    sme_match_serializer dut (
        .clk          (clk),
        .rst          (rst),
        .s_rule_data  (s_data),
        .s_rule_valid (s_valid),
        .s_rule_eop   (s_eop),
        .s_rule_ready (s_ready),
        .m_rule_id    (m_id),
        .m_rule_valid (m_valid),
        .m_rule_last  (m_last),
        .m_rule_cnt   (m_cnt),
        .m_rule_ready (m_ready)
    );

    function automatic logic [127:0] mk(input logic [15:0] a0, input logic [15:0] a1,
                                        input logic [15:0] a2, input logic [15:0] a3,
                                        input logic [15:0] a4, input logic [15:0] a5,
                                        input logic [15:0] a6, input logic [15:0] a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic vec_t mkvec(input logic [127:0] d, input int n, input logic [127:0] ids,
                                   input logic [15:0] cnt);
        vec_t v;
        v.data = d;
        v.n    = 4'(n);
        v.ids  = ids;
        v.cnt  = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: actual=timeout required=event", name);
    endtask

    // Reference model: every accepted beat contributes its non-zero lanes in lane order.
    task automatic model_accept(input logic [127:0] d, input logic eop);
        logic [15:0] v;
        for (int i = 0; i < 8; i++) begin
            v = d[i*16 +: 16];
`ifdef SME_SER_DEDUP_EN
            if (v != 16'h0000 && !(mdl_last_ok && v == mdl_last)) begin
`else
            if (v != 16'h0000) begin
`endif
                exp_q.push_back({v, 1'b0, 16'h0000});
                mdl_cnt++;
                mdl_last    = v;
                mdl_last_ok = 1'b1;
            end
        end
        if (eop) begin
            exp_q.push_back({16'h0000, 1'b1, (mdl_cnt > 65535) ? 16'hFFFF : mdl_cnt[15:0]});
            mdl_cnt     = 0;
            mdl_last_ok = 1'b0;
        end
    endtask

    // Output monitor: scoreboard compare, hold-stability check, model feed on input accepts.
    initial begin : monitor
        logic [32:0] w;
        logic [32:0] e;
        logic [32:0] held;
        logic        stall;
        stall = 1'b0;
        held  = 33'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                mdl_cnt     = 0;
                mdl_last_ok = 1'b0;
                stall       = 1'b0;
            end else begin
                w = {m_id, m_last, (m_last ? m_cnt : 16'h0000)};
                if (stall) begin
                    chk("hold_valid", 64'(m_valid), 64'd1);
                    chk("hold_word", 64'(w), 64'(held));
                end
                if (m_valid && m_ready) begin
                    obs_q.push_back(w);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL scoreboard_extra: actual=0x%0h required=none", w);
                    end else begin
                        e = exp_q.pop_front();
                        chk("scoreboard_word", 64'(w), 64'(e));
                    end
                end
                stall = m_valid & ~m_ready;
                held  = w;
                if (s_valid && s_ready) begin
                    model_accept(s_data, s_eop);
                end
            end
        end
    end

    // Downstream ready driver: held low, held high, or random 50%.
    initial begin : ready_drv
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rdy_mode == 2) begin
                m_ready = 1'($urandom_range(0, 1));
            end else begin
                m_ready = (rdy_mode == 1);
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send_beat(input logic [127:0] d, input logic eop);
        int t;
        t = 0;
        @(posedge clk);
        #1;
        s_data  = d;
        s_eop   = eop;
        s_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!s_ready && t < 2000);
        if (!s_ready) begin
            fail_now("send_beat_ready");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_eop   = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !s_ready) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            fail_now("drain");
        end
    endtask

    task automatic check_obs(input string tag, input logic [255:0] ids, input int n,
                             input logic [15:0] cnt);
        chk({tag, "_len"}, 64'(obs_q.size()), 64'(n + 1));
        if (obs_q.size() == n + 1) begin
            for (int j = 0; j < n; j++) begin
                chk({tag, "_id"}, 64'(obs_q[j][32:17]), 64'(ids[j*16 +: 16]));
                chk({tag, "_dlast"}, 64'(obs_q[j][16]), 64'd0);
            end
            chk({tag, "_mark_id"}, 64'(obs_q[n][32:17]), 64'd0);
            chk({tag, "_mark_last"}, 64'(obs_q[n][16]), 64'd1);
            chk({tag, "_mark_cnt"}, 64'(obs_q[n][15:0]), 64'(cnt));
        end
    endtask

    initial begin : main
        logic [127:0] d;
        logic [15:0]  v;
        int           nb;
        int           t;
        rst     = 1'b1;
        s_data  = 128'h0;
        s_valid = 1'b0;
        s_eop   = 1'b0;

        vecs[0] = mkvec(mk(16'h0, 16'h0012, 16'h0, 16'h0034, 16'h0, 16'h0, 16'h0, 16'h0), 2,
                        mk(16'h0012, 16'h0034, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 16'd2);
        vecs[1] = mkvec(128'h0, 0, 128'h0, 16'd0);
        vecs[2] = mkvec(mk(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888), 8,
                        mk(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888), 16'd8);
`ifdef SME_SER_DEDUP_EN
        vecs[3] = mkvec(mk(16'h0007, 16'h0007, 16'h0009, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 2,
                        mk(16'h0007, 16'h0009, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 16'd2);
`else
        vecs[3] = mkvec(mk(16'h0007, 16'h0007, 16'h0009, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 3,
                        mk(16'h0007, 16'h0007, 16'h0009, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 16'd3);
`endif
        vecs[4] = mkvec(mk(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF), 1,
                        mk(16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 16'd1);
        vecs[5] = mkvec(mk(16'hA001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hA007), 2,
                        mk(16'hA001, 16'hA007, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 16'd2);

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_id", 64'(m_id), 64'd0);
        chk("rst_m_cnt", 64'(m_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        t = 0;
        while (!s_ready && t < 3) begin
            @(negedge clk);
            t++;
        end
        chk("ready_after_reset", 64'(s_ready), 64'd1);

        // Single beat: next-cycle latency, lane order, marker, ready back after marker.
        obs_q.delete();
        send_beat(vecs[0].data, 1'b1);
        @(negedge clk);
        chk("t1_valid0", 64'(m_valid), 64'd1);
        chk("t1_id0", 64'(m_id), 64'h0012);
        @(negedge clk);
        chk("t1_id1", 64'(m_id), 64'h0034);
        @(negedge clk);
        chk("t1_mark_last", 64'(m_last), 64'd1);
        chk("t1_mark_cnt", 64'(m_cnt), 64'd2);
        chk("t1_mark_sready", 64'(s_ready), 64'd0);
        @(negedge clk);
        chk("t1_sready_back", 64'(s_ready), 64'd1);
        wait_drain();

        // Table vectors, one eop beat each, downstream always ready.
        for (int k = 0; k < 6; k++) begin
            obs_q.delete();
            send_beat(vecs[k].data, 1'b1);
            wait_drain();
            check_obs($sformatf("vec%0d", k), {128'h0, vecs[k].ids}, int'(vecs[k].n), vecs[k].cnt);
        end

        // Three beats 8/0/1 non-zero lanes with random downstream ready.
        rdy_mode = 2;
        obs_q.delete();
        send_beat(mk(16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0106, 16'h0107, 16'h0108), 1'b0);
        send_beat(128'h0, 1'b0);
        send_beat(mk(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0200, 16'h0, 16'h0), 1'b1);
        wait_drain();
        check_obs("three_beats",
                  {112'h0, 16'h0200, mk(16'h0101, 16'h0102, 16'h0103, 16'h0104,
                                        16'h0105, 16'h0106, 16'h0107, 16'h0108)}, 9, 16'd9);

        // Backpressure for 20 cycles with a beat buffered.
        rdy_mode = 0;
        obs_q.delete();
        d = mk(16'hB001, 16'hB002, 16'hB003, 16'hB004, 16'hB005, 16'hB006, 16'hB007, 16'hB008);
        send_beat(d, 1'b1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("bp_s_ready", 64'(s_ready), 64'd0);
            chk("bp_m_valid", 64'(m_valid), 64'd1);
            chk("bp_m_id", 64'(m_id), 64'hB001);
        end
        rdy_mode = 1;
        wait_drain();
        check_obs("backpressure", {128'h0, d}, 8, 16'd8);

        // Reset while draining discards pending IDs and count.
        rdy_mode = 0;
        send_beat(mk(16'hC001, 16'hC002, 16'hC003, 16'hC004, 16'hC005, 16'h0, 16'h0, 16'h0), 1'b0);
        @(negedge clk);
        chk("pre_rst_valid", 64'(m_valid), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valid", 64'(m_valid), 64'd0);
        chk("mid_rst_last", 64'(m_last), 64'd0);
        chk("mid_rst_id", 64'(m_id), 64'd0);
        chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        rdy_mode = 1;
        obs_q.delete();
        send_beat(mk(16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 1'b1);
        wait_drain();
        check_obs("after_rst", {240'h0, 16'h0001}, 1, 16'd1);

        // Duplicates across two beats of one packet.
        obs_q.delete();
        send_beat(mk(16'h0007, 16'h0007, 16'h0009, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 1'b0);
        send_beat(mk(16'h0009, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 1'b1);
        wait_drain();
`ifdef SME_SER_DEDUP_EN
        check_obs("dedup", {224'h0, 16'h0009, 16'h0007}, 2, 16'd2);
`else
        check_obs("dedup", {192'h0, 16'h0009, 16'h0009, 16'h0007, 16'h0007}, 4, 16'd4);
`endif

        // Randomized packets against the reference model.
        rdy_mode = 2;
        for (int p = 0; p < 30; p++) begin
            nb = int'($urandom_range(1, 3));
            for (int b = 0; b < nb; b++) begin
                for (int i = 0; i < 8; i++) begin
                    case ($urandom_range(0, 3))
                        0:       v = 16'($urandom);
                        1:       v = 16'($urandom_range(1, 3));
                        default: v = 16'h0000;
                    endcase
                    d[i*16 +: 16] = v;
                end
                send_beat(d, (b == nb - 1));
            end
        end
        wait_drain();
        chk("final_exp_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
